conv_layer_sequencer: RTL and testbench
=======================================

Name: conv_layer_sequencer

Overview:
Sequences the convolution engine across all output channels of one layer. A single start pulse launches the engine once per channel. The block counts the engine's valid output pixels, applies ReLU, and emits a registered output stream with an end-of-image marker per channel and a done pulse after the last channel. It sits between top-level control and the conv engine, and replaces ad-hoc ReLU and end-of-image handling outside the engine.

Parameters:
DATA_W, 24, width of engine output and block output data (two's complement)
IMG_W, 28, output pixels per row
IMG_H, 28, output rows per channel image
NUM_CH, 8, number of output channels (engine launches) per layer; must be >= 1

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle (or longer) request to run a layer; sampled only in IDLE
eng_start  out  1  one-cycle launch pulse to the conv engine
eng_valid  in  1  engine output pixel valid
eng_data  in  DATA_W  engine output pixel
out_data  out  DATA_W  ReLU-applied pixel, registered
data_validity  out  1  out_data valid this cycle
img_end  out  1  high with the last pixel of each channel image
done  out  1  one-cycle pulse when the layer is finished
busy  out  1  high from accepting start until done is asserted
ch_idx  out  $clog2(NUM_CH) (min 1)  channel currently being processed
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst=1): state=IDLE. All outputs are 0: out_data, data_validity, img_end, done, busy, ch_idx, eng_start, err. pix_cnt=0.
- States: IDLE, LAUNCH, RUN, CH_END, FINISH.
- IDLE:
  - start=1 → LAUNCH.
  - On that transition: ch_idx<=0, err<=0, busy<=1.
- LAUNCH:
  - eng_start=1 for exactly this cycle (registered output, visible the cycle after entering LAUNCH).
  - pix_cnt<=0.
  - → RUN.
- RUN, per cycle with eng_valid=1:
  - out_data<=(eng_data[DATA_W-1]?0:eng_data); data_validity<=1. Latency is 1 clk from eng_valid.
  - If pix_cnt==IMG_W*IMG_H-1: img_end<=1 (same cycle as that pixel's data_validity), then → CH_END.
  - Otherwise pix_cnt++.
  - Cycles with eng_valid=0 give data_validity=0 and no count change. Gaps of any length are allowed.
- CH_END (one cycle):
  - If ch_idx==NUM_CH-1 → FINISH.
  - Else ch_idx++ and → LAUNCH.
  - The back-to-back launch gap is therefore fixed at 2 cycles after the last valid.
- FINISH: done<=1 for one cycle, busy<=0, → IDLE.
- data_validity and img_end are single-cycle registered pulses; they default to 0 whenever not set.
- start while busy: ignored, with no effect on count or state.
- eng_valid outside RUN (IDLE, LAUNCH, CH_END, FINISH): the pixel is dropped, data_validity stays 0, err<=1. err is sticky until the next accepted start or reset.
- Counter width: $clog2(IMG_W*IMG_H) bits. The compare uses the full product; no wrap occurs before the compare.
- rst asserted mid-operation: immediate return to reset values. No done is produced, and no eng_start is issued after reset deasserts until a new start.
- NUM_CH=1: CH_END → FINISH directly. ch_idx stays 0.

Decomposition:
- Package conv_ctrl_pkg holds:
  - the state enum (IDLE, LAUNCH, RUN, CH_END, FINISH);
  - the DATA_W default;
  - a relu function (sign test, returns zero or input).
- Sub-module img_pixel_counter, parameterised by IMG_W and IMG_H:
  - inputs: clear, inc;
  - outputs: last (pix_cnt==IMG_W*IMG_H-1) and count.
- The FSM, output registers and the channel counter stay in the top.

Test Plan (IMG_W=3, IMG_H=2, NUM_CH=2 unless noted):
1. Reset, then start pulse at cycle 10 → eng_start high for exactly one cycle at cycle 12, busy=1 from cycle 11.
2. Feed 6 consecutive eng_valid pixels 0x000005, 0xFFFFFE, 0x7FFFFF, 0x800000, 0x000000, 0x000010 → out_data 5, 0, 7FFFFF, 0, 0, 10, each 1 cycle later. img_end high only with 0x000010. A second eng_start appears 2 cycles after the last valid, and ch_idx=1.
3. Complete the second channel with gaps (eng_valid every 3rd cycle) → exactly 6 data_validity pulses and one img_end, then a single-cycle done, busy=0. Total data_validity count over the layer is 12.
4. Pulse start during RUN of channel 0 → no extra eng_start, pixel count unchanged, layer completes normally.
5. eng_valid=1 in IDLE with eng_data=0x000123 → data_validity stays 0 and err=1. err stays 1 until the next start is accepted, then reads 0.
6. Assert rst after 4 pixels of channel 1 → all outputs 0 asynchronously, no done. A new start restarts from ch_idx=0 with a full 6-pixel count.

Source files
------------

// File: rtl/conv_ctrl_pkg.sv
// Shared types and helpers for the convolution layer sequencer.
package conv_ctrl_pkg;

    localparam int DATA_W_DEFAULT = 24;
    localparam int RELU_MAX_W     = 64;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        RUN    = 3'd2,
        CH_END = 3'd3,
        FINISH = 3'd4
    } seq_state_t;

    // Width-agnostic ReLU: sign_pos selects the sign bit of the caller's data width.
    function automatic logic [RELU_MAX_W-1:0] relu(input logic [RELU_MAX_W-1:0] x,
                                                   input logic [5:0] sign_pos);
        return x[sign_pos] ? '0 : x;
    endfunction

endpackage

// File: rtl/img_pixel_counter.sv
// Counts valid output pixels within one channel image and flags the final one.
module img_pixel_counter #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    localparam int TOTAL = IMG_W * IMG_H,
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             inc,
    output logic             last,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

    assign last = (count == CNT_W'(TOTAL - 1));

endmodule

// File: rtl/conv_layer_sequencer.sv
// Launches the conv engine once per output channel, applies ReLU to its pixels
// and marks image ends and layer completion.
//
// state  | meaning
// IDLE   | waiting for start
// LAUNCH | engine launch pulse issued next cycle, pixel count cleared
// RUN    | accepting engine pixels for the current channel
// CH_END | channel image complete, pick next channel or finish
// FINISH | layer complete, done pulse issued next cycle
module conv_layer_sequencer
    import conv_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int NUM_CH = 8,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int TOTAL = IMG_W * IMG_H,
    localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              eng_start,
    input  logic              eng_valid,
    input  logic [DATA_W-1:0] eng_data,
    output logic [DATA_W-1:0] out_data,
    output logic              data_validity,
    output logic              img_end,
    output logic              done,
    output logic              busy,
    output logic [CH_W-1:0]   ch_idx,
    output logic              err
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic             accept;
    logic             cnt_clear;
    logic             cnt_inc;
    logic             pix_last;
    logic             last_ch;
    logic             pix_taken;
    logic [CNT_W-1:0] pix_count;

    img_pixel_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pix_cnt (
        .clk   (clk),
        .rst   (rst),
        .clear (cnt_clear),
        .inc   (cnt_inc),
        .last  (pix_last),
        .count (pix_count)
    );

    assign last_ch   = (ch_idx == CH_W'(NUM_CH - 1));
    assign pix_taken = (state == RUN) && eng_valid;

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_clear  = 1'b1;
                state_next = RUN;
            end
            RUN: begin
                if (eng_valid) begin
                    if (pix_last) state_next = CH_END;
                    else          cnt_inc    = 1'b1;
                end
            end
            CH_END:  state_next = last_ch ? FINISH : LAUNCH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            eng_start     <= 1'b0;
            out_data      <= '0;
            data_validity <= 1'b0;
            img_end       <= 1'b0;
            done          <= 1'b0;
            busy          <= 1'b0;
            ch_idx        <= '0;
            err           <= 1'b0;
        end else begin
            state         <= state_next;
            eng_start     <= (state == LAUNCH);
            data_validity <= pix_taken;
            img_end       <= pix_taken && pix_last;
            done          <= (state == FINISH);

            if (pix_taken) begin
                out_data <= DATA_W'(relu(RELU_MAX_W'(eng_data), 6'(DATA_W - 1)));
            end

            if (accept) begin
                ch_idx <= '0;
                busy   <= 1'b1;
            end else if (state == CH_END && !last_ch) begin
                ch_idx <= ch_idx + CH_W'(1);
            end else if (state == FINISH) begin
                busy <= 1'b0;
            end

            // A stray pixel in the same cycle as an accepted start still counts as an error.
            err <= (err && !accept) || (eng_valid && state != RUN);
        end
    end

    a_pix_count_range : assert property (@(posedge clk) disable iff (rst)
        pix_count <= CNT_W'(TOTAL - 1));

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer on a 3x2 image, two-channel layer.
module tb_conv_layer_sequencer;

    localparam int DW = 24;
    localparam int NP = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          eng_start;
    logic          eng_valid;
    logic [DW-1:0] eng_data;
    logic [DW-1:0] out_data;
    logic          data_validity;
    logic          img_end;
    logic          done;
    logic          busy;
    logic [0:0]    ch_idx;
    logic          err;

    int vectors     = 0;
    int miscompares = 0;
    int dv_cnt      = 0;
    int ie_cnt      = 0;
    int es_cnt      = 0;
    int done_cnt    = 0;
    int b_dv, b_ie, b_es, b_done;

    logic [DW-1:0] p_in  [NP] = '{24'h000005, 24'hFFFFFE, 24'h7FFFFF, 24'h800000, 24'h000000, 24'h000010};
    logic [DW-1:0] p_out [NP] = '{24'h000005, 24'h000000, 24'h7FFFFF, 24'h000000, 24'h000000, 24'h000010};
    logic [DW-1:0] q_in  [NP] = '{24'h000001, 24'h800001, 24'h123456, 24'hFFFFFF, 24'h400000, 24'h00ABCD};
    logic [DW-1:0] q_out [NP] = '{24'h000001, 24'h000000, 24'h123456, 24'h000000, 24'h400000, 24'h00ABCD};

    conv_layer_sequencer #(
        .DATA_W (DW),
        .IMG_W  (3),
        .IMG_H  (2),
        .NUM_CH (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .eng_start     (eng_start),
        .eng_valid     (eng_valid),
        .eng_data      (eng_data),
        .out_data      (out_data),
        .data_validity (data_validity),
        .img_end       (img_end),
        .done          (done),
        .busy          (busy),
        .ch_idx        (ch_idx),
        .err           (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst) begin
            dv_cnt   += int'(data_validity);
            ie_cnt   += int'(img_end);
            es_cnt   += int'(eng_start);
            done_cnt += int'(done);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_pixel(input logic [DW-1:0] d, input logic [DW-1:0] e, input bit last);
        eng_valid = 1'b1;
        eng_data  = d;
        step();
        eng_valid = 1'b0;
        check_val("pix_valid", 32'(data_validity), 32'd1);
        check_val("pix_data", 32'(out_data), 32'(e));
        check_val("pix_img_end", 32'(img_end), 32'(last));
    endtask

    task automatic run_channel(input bit use_q, input int gap);
        for (int i = 0; i < NP; i++) begin
            for (int g = 0; g < gap; g++) begin
                step();
                check_val("gap_valid", 32'(data_validity), 32'd0);
            end
            if (use_q) feed_pixel(q_in[i], q_out[i], i == NP - 1);
            else       feed_pixel(p_in[i], p_out[i], i == NP - 1);
        end
    endtask

    task automatic wait_eng_start();
        int n = 0;
        while (eng_start !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check_val("eng_start_seen", 32'(eng_start), 32'd1);
    endtask

    task automatic finish_done();
        step();
        check_val("done_early", 32'(done), 32'd0);
        step();
        check_val("done_pulse", 32'(done), 32'd1);
        check_val("busy_at_done", 32'(busy), 32'd0);
        step();
        check_val("done_single", 32'(done), 32'd0);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        eng_valid = 1'b0;
        eng_data  = '0;
        repeat (3) step();
        check_val("rst_out_data", 32'(out_data), 32'd0);
        check_val("rst_valid", 32'(data_validity), 32'd0);
        check_val("rst_img_end", 32'(img_end), 32'd0);
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_ch_idx", 32'(ch_idx), 32'd0);
        check_val("rst_eng_start", 32'(eng_start), 32'd0);
        check_val("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        repeat (6) step();

        // start -> busy next cycle, eng_start the cycle after
        b_dv = dv_cnt; b_ie = ie_cnt; b_es = es_cnt; b_done = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("t1_busy", 32'(busy), 32'd1);
        check_val("t1_es_early", 32'(eng_start), 32'd0);
        step();
        check_val("t1_eng_start", 32'(eng_start), 32'd1);
        check_val("t1_ch_idx", 32'(ch_idx), 32'd0);

        // channel 0 back-to-back, then relaunch of channel 1
        run_channel(1'b0, 0);
        check_val("t2_es_once", 32'(es_cnt - b_es), 32'd1);
        step();
        check_val("t2_es_gap", 32'(eng_start), 32'd0);
        check_val("t2_ch_idx", 32'(ch_idx), 32'd1);
        check_val("t2_valid_off", 32'(data_validity), 32'd0);
        step();
        check_val("t2_eng_start2", 32'(eng_start), 32'd1);

        // channel 1 with two idle cycles before each pixel
        run_channel(1'b1, 2);
        finish_done();
        check_val("t3_dv_total", 32'(dv_cnt - b_dv), 32'd12);
        check_val("t3_img_end_total", 32'(ie_cnt - b_ie), 32'd2);
        check_val("t3_es_total", 32'(es_cnt - b_es), 32'd2);
        check_val("t3_done_total", 32'(done_cnt - b_done), 32'd1);

        // stray pixel in IDLE
        eng_valid = 1'b1;
        eng_data  = 24'h000123;
        step();
        eng_valid = 1'b0;
        check_val("t5_valid", 32'(data_validity), 32'd0);
        check_val("t5_err", 32'(err), 32'd1);
        repeat (3) step();
        check_val("t5_err_sticky", 32'(err), 32'd1);
        b_dv = dv_cnt; b_es = es_cnt; b_done = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("t5_err_clear", 32'(err), 32'd0);

        // start pulsed mid-channel is ignored
        step();
        check_val("t4_eng_start", 32'(eng_start), 32'd1);
        feed_pixel(p_in[0], p_out[0], 1'b0);
        feed_pixel(p_in[1], p_out[1], 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("t4_no_valid", 32'(data_validity), 32'd0);
        for (int i = 2; i < NP; i++) feed_pixel(p_in[i], p_out[i], i == NP - 1);
        wait_eng_start();
        run_channel(1'b1, 0);
        finish_done();
        check_val("t4_es_total", 32'(es_cnt - b_es), 32'd2);
        check_val("t4_dv_total", 32'(dv_cnt - b_dv), 32'd12);
        check_val("t4_busy_idle", 32'(busy), 32'd0);

        // async reset in the middle of channel 1
        b_done = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_eng_start();
        run_channel(1'b0, 0);
        wait_eng_start();
        check_val("t6_ch_idx1", 32'(ch_idx), 32'd1);
        for (int i = 0; i < 4; i++) feed_pixel(q_in[i], q_out[i], 1'b0);
        #2 rst = 1'b1;
        #1;
        check_val("t6_rst_out_data", 32'(out_data), 32'd0);
        check_val("t6_rst_valid", 32'(data_validity), 32'd0);
        check_val("t6_rst_busy", 32'(busy), 32'd0);
        check_val("t6_rst_ch_idx", 32'(ch_idx), 32'd0);
        check_val("t6_rst_done", 32'(done), 32'd0);
        check_val("t6_rst_err", 32'(err), 32'd0);
        repeat (2) step();
        rst = 1'b0;
        b_es = es_cnt;
        repeat (5) step();
        check_val("t6_no_done", 32'(done_cnt - b_done), 32'd0);
        check_val("t6_no_launch", 32'(es_cnt - b_es), 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        check_val("t6_busy", 32'(busy), 32'd1);
        check_val("t6_ch_idx0", 32'(ch_idx), 32'd0);
        step();
        check_val("t6_eng_start", 32'(eng_start), 32'd1);
        run_channel(1'b1, 0);
        wait_eng_start();
        run_channel(1'b0, 1);
        finish_done();
        check_val("t6_done_total", 32'(done_cnt - b_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
